// File: rtl/accelerator_pkg.sv
`default_nettype none
//==============================================================================
// Module   : accelerator_pkg
// Brief    : Shared types and helpers for the vector load/store unit.
// Revision : 1.0 - initial release
//==============================================================================
package accelerator_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACTIVE = 2'd1,
        LSU_DONE   = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SEW_8    = 2'd0,
        SEW_16   = 2'd1,
        SEW_32   = 2'd2,
        SEW_RSVD = 2'd3
    } vsew_t;

    // Element size in bytes; 0 flags the reserved encoding.
    function automatic logic [2:0] elem_bytes(input logic [1:0] sew);
        case (sew)
            SEW_8:   return 3'd1;
            SEW_16:  return 3'd2;
            SEW_32:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_addr_gen.sv
`default_nettype none
//==============================================================================
// Module   : lsu_addr_gen
// Brief    : Element address, byte-enable, write replication and read alignment.
// Revision : 1.0 - initial release
//==============================================================================
module lsu_addr_gen
    import accelerator_pkg::*;
#(
    parameter int IDX_W = 5
) (
    input  logic [31:0]      base_addr,
    input  logic [31:0]      stride,
    input  logic [IDX_W-1:0] idx,
    input  logic [1:0]       vsew,
    input  logic [31:0]      elem_data,
    input  logic [1:0]       resp_offset,
    input  logic [31:0]      rdata,
    output logic [31:0]      addr,
    output logic [3:0]       be,
    output logic [31:0]      wdata,
    output logic [31:0]      rdata_aligned
);

    always_comb begin
        // Truncated product gives the modulo-2^32 address for negative strides too.
        addr = base_addr + stride * {{(32-IDX_W){1'b0}}, idx};
        case (vsew)
            SEW_8:   be = 4'b0001 << addr[1:0];
            SEW_16:  be = 4'b0011 << addr[1:0];
            SEW_32:  be = 4'b1111 << addr[1:0];
            default: be = 4'b0000;
        endcase
        case (vsew)
            SEW_8:   wdata = {4{elem_data[7:0]}};
            SEW_16:  wdata = {2{elem_data[15:0]}};
            default: wdata = elem_data;
        endcase
        rdata_aligned = rdata >> {resp_offset, 3'b000};
    end

endmodule
`default_nettype wire

// File: rtl/vector_lsu.sv
`default_nettype none
//==============================================================================
// Module   : vector_lsu
// Brief    : Strided vector load/store engine issuing one OBI transaction per element.
// Revision : 1.0 - initial release
//==============================================================================
module vector_lsu
    import accelerator_pkg::*;
#(
    parameter int VLEN            = 128,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    start,
    input  logic                    is_store,
    input  logic [31:0]             base_addr,
    input  logic [31:0]             stride,
    input  logic [$clog2(VLEN/8):0] vl,
    input  logic [1:0]              vsew,
    input  logic [VLEN-1:0]         store_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [VLEN-1:0]         load_data,
    output logic [VLEN/8-1:0]       load_byte_en,
    output logic                    data_req_o,
    output logic                    data_we_o,
    output logic [3:0]              data_be_o,
    output logic [31:0]             data_addr_o,
    output logic [31:0]             data_wdata_o,
    input  logic                    data_gnt_i,
    input  logic                    data_rvalid_i,
    input  logic [31:0]             data_rdata_i
);

    localparam int         NBYTES  = VLEN / 8;
    localparam int         VL_W    = $clog2(NBYTES) + 1;
    localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

    lsu_state_t          state_q, state_d;
    logic                is_store_q, is_store_d;
    logic                err_q, err_d;
    logic [31:0]         base_q, base_d;
    logic [31:0]         stride_q, stride_d;
    logic [VL_W-1:0]     vl_q, vl_d;
    logic [VL_W-1:0]     issue_q, issue_d;
    logic [VL_W-1:0]     resp_q, resp_d;
    logic [1:0]          vsew_q, vsew_d;
    logic [1:0]          resp_off_q, resp_off_d;
    logic [2:0]          outst_q, outst_d;
    logic [VLEN-1:0]     store_data_q, store_data_d;
    logic [VLEN-1:0]     load_data_q, load_data_d;
    logic [NBYTES-1:0]   load_be_q, load_be_d;

    logic [2:0]  new_esz, esz;
    logic [1:0]  align_mask;
    logic [31:0] eff_stride;
    logic        illegal, req, grant, resp;
    logic [31:0] elem_wdata, gen_addr, gen_wdata, rdata_al;
    logic [3:0]  gen_be;

    lsu_addr_gen #(
        .IDX_W (VL_W)
    ) u_addr_gen (
        .base_addr     (base_q),
        .stride        (stride_q),
        .idx           (issue_q),
        .vsew          (vsew_q),
        .elem_data     (elem_wdata),
        .resp_offset   (resp_off_q),
        .rdata         (data_rdata_i),
        .addr          (gen_addr),
        .be            (gen_be),
        .wdata         (gen_wdata),
        .rdata_aligned (rdata_al)
    );

    always_comb begin
        new_esz    = elem_bytes(vsew);
        align_mask = {vsew[1], vsew[1] | vsew[0]};
        eff_stride = (stride == 32'd0) ? {29'd0, new_esz} : stride;
        illegal    = (vsew == SEW_RSVD)
                  || ({{(32-VL_W){1'b0}}, vl} > (32'(NBYTES) >> vsew))
                  || ((base_addr[1:0] & align_mask) != 2'b00)
                  || ((eff_stride[1:0] & align_mask) != 2'b00);

        esz   = elem_bytes(vsew_q);
        req   = (state_q == LSU_ACTIVE) && (issue_q < vl_q) && (outst_q < MAX_OUT);
        grant = req && data_gnt_i;
        resp  = (state_q == LSU_ACTIVE) && data_rvalid_i && (outst_q != 3'd0);

        elem_wdata = '0;
        for (int b = 0; b < 4; b++) begin
            if (b < int'(esz) && (int'(issue_q) * int'(esz) + b) < NBYTES)
                elem_wdata[b*8 +: 8] = store_data_q[(int'(issue_q) * int'(esz) + b)*8 +: 8];
        end

        state_d      = state_q;
        is_store_d   = is_store_q;
        err_d        = err_q;
        base_d       = base_q;
        stride_d     = stride_q;
        vl_d         = vl_q;
        issue_d      = issue_q;
        resp_d       = resp_q;
        vsew_d       = vsew_q;
        resp_off_d   = resp_off_q;
        outst_d      = outst_q;
        store_data_d = store_data_q;
        load_data_d  = load_data_q;
        load_be_d    = load_be_q;

        case (state_q)
            LSU_IDLE: begin
                if (start) begin
                    is_store_d   = is_store;
                    base_d       = base_addr;
                    stride_d     = eff_stride;
                    vl_d         = vl;
                    vsew_d       = vsew;
                    store_data_d = store_data;
                    issue_d      = '0;
                    resp_d       = '0;
                    outst_d      = '0;
                    resp_off_d   = base_addr[1:0];
                    load_data_d  = '0;
                    load_be_d    = '0;
                    err_d        = illegal;
                    state_d      = (illegal || vl == '0) ? LSU_DONE : LSU_ACTIVE;
                end
            end
            LSU_ACTIVE: begin
                if (grant)
                    issue_d = issue_q + VL_W'(1);
                outst_d = outst_q + {2'b00, grant} - {2'b00, resp};
                if (resp) begin
                    resp_d     = resp_q + VL_W'(1);
                    // Byte offset of the next response tracks the stride modulo 4.
                    resp_off_d = resp_off_q + stride_q[1:0];
                    if (!is_store_q) begin
                        for (int b = 0; b < 4; b++) begin
                            if (b < int'(esz) && (int'(resp_q) * int'(esz) + b) < NBYTES) begin
                                load_data_d[(int'(resp_q) * int'(esz) + b)*8 +: 8] = rdata_al[b*8 +: 8];
                                load_be_d[int'(resp_q) * int'(esz) + b] = 1'b1;
                            end
                        end
                    end
                    if (resp_q + VL_W'(1) == vl_q)
                        state_d = LSU_DONE;
                end
            end
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= LSU_IDLE;
            is_store_q   <= 1'b0;
            err_q        <= 1'b0;
            base_q       <= '0;
            stride_q     <= '0;
            vl_q         <= '0;
            issue_q      <= '0;
            resp_q       <= '0;
            vsew_q       <= '0;
            resp_off_q   <= '0;
            outst_q      <= '0;
            store_data_q <= '0;
            load_data_q  <= '0;
            load_be_q    <= '0;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            err_q        <= err_d;
            base_q       <= base_d;
            stride_q     <= stride_d;
            vl_q         <= vl_d;
            issue_q      <= issue_d;
            resp_q       <= resp_d;
            vsew_q       <= vsew_d;
            resp_off_q   <= resp_off_d;
            outst_q      <= outst_d;
            store_data_q <= store_data_d;
            load_data_q  <= load_data_d;
            load_be_q    <= load_be_d;
        end
    end

    assign busy         = (state_q != LSU_IDLE);
    assign done         = (state_q == LSU_DONE);
    assign err          = done && err_q;
    assign load_data    = load_data_q;
    assign load_byte_en = load_be_q;
    assign data_req_o   = req;
    assign data_we_o    = req && is_store_q;
    assign data_be_o    = req ? gen_be    : 4'b0000;
    assign data_addr_o  = req ? gen_addr  : 32'd0;
    assign data_wdata_o = req ? gen_wdata : 32'd0;

endmodule
`default_nettype wire
